div_param: RTL
==============

# div_param

Parametrised multi-cycle radix-2 restoring divider, the next-generation successor to the fixed 32-bit pipeline divider. It sits beside the EX stage: EX drives operands, sign mode and `start_i`, and holds the pipeline stalled until `ready_o`. `annul_i` cancels a division in flight. Adds over the 32-bit divider: generic `WIDTH`, operand latching at start, a `busy_o` status and a sticky divide-by-zero flag.

## Interface
- `WIDTH`, 32, operand width in bits; legal for ≥ 2. Result width is 2·`WIDTH`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `signed_div_i`  in  1  1 = two's-complement divide, 0 = unsigned; sampled with `start_i`.
- `opdata1_i`  in  `WIDTH`  dividend; sampled with `start_i`.
- `opdata2_i`  in  `WIDTH`  divisor; sampled with `start_i`.
- `start_i`  in  1  request; held high by EX until it sees `ready_o`.
- `annul_i`  in  1  cancel the current operation.
- `result_o`  out  2·`WIDTH`  {remainder, quotient}; remainder is the upper half.
- `ready_o`  out  1  result valid.
- `busy_o`  out  1  high in states BY_ZERO and ON.
- `div_zero_o`  out  1  current result came from a zero divisor; valid while `ready_o` is high.

## Operation
- States: FREE, BY_ZERO, ON, END. Reset goes to FREE and clears all registers.
- Registered internal state: dividend register (2·`WIDTH`+1 bits), latched divisor, `cnt` (width clog2(`WIDTH`+1)), sign flags.
- **FREE**
  - `start_i`=1 and `annul_i`=0 latches the operands and sign mode.
  - Divisor == 0 → BY_ZERO.
  - Otherwise:
    - Signed mode: each negative operand is replaced by its two's-complement magnitude.
    - Record `qneg` = sign1 XOR sign2 and `rneg` = sign1.
    - Load the dividend register with {0, |dividend|}, set `cnt`=0, go to ON.
  - `start_i`=1 together with `annul_i`=1 is ignored; the state stays FREE.
- **BY_ZERO**: next edge goes to END with `result_o`=0 and `div_zero_o`=1.
- **ON**
  - `annul_i`=1 → FREE; `cnt` cleared; no result is produced.
  - `cnt` < `WIDTH`: one restoring step per cycle, then `cnt`+1.
    - Shift the dividend register left 1.
    - Compute `diff` = upper(`WIDTH`+1) − {0, divisor}.
    - If `diff` ≥ 0: upper ← `diff` and LSB ← 1; otherwise LSB ← 0.
  - `cnt` == `WIDTH`: apply signs, then go to END with `ready_o`=1.
    - quotient = `qneg` ? −q : q.
    - remainder = `rneg` ? −r : r.
    - All arithmetic is modulo 2^`WIDTH`.
- **END**
  - Holds `result_o`, `ready_o`=1 and `div_zero_o` while `start_i`=1.
  - `start_i`=0 → FREE, with `ready_o`, `result_o` and `div_zero_o` cleared to 0.
  - `annul_i` in END also → FREE, with outputs cleared.
- Signed overflow: −2^(`WIDTH`−1) / −1 gives quotient 2^(`WIDTH`−1) (bit pattern unchanged, wrap) and remainder 0. No flag is raised.
- Remainder sign follows the dividend; the magnitude of the remainder is less than the magnitude of the divisor.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Normal divide:
  - Edge E0 samples `start_i` in FREE.
  - Edges E1..E`WIDTH` perform the quotient steps.
  - Edge E`WIDTH`+1 loads `result_o` and raises `ready_o`.
  - Latency is `WIDTH`+1 cycles; 33 for `WIDTH`=32.
- Zero divisor: `ready_o` rises after E1 (latency 1).
- `busy_o` rises after E0 and falls in the same cycle `ready_o` rises. It also falls one edge after annul.
- Back-to-back: after `start_i` drops, END → FREE takes one edge. A new `start_i` is accepted on the following edge, so there is a minimum 1 idle cycle between results.
- Annul during ON takes effect on the next edge; `ready_o` never rises for the annulled operation.
- Reset overrides everything, including mid-operation: the state is FREE on the next edge and all outputs are 0.
- Operand inputs may change freely after E0; only the values latched at E0 are used.

## Test plan
- Unsigned, `WIDTH`=32: 100 / 7, `start_i` held → `ready_o`=1 exactly 33 cycles after the start edge; `result_o`={32'd2, 32'd14}; `div_zero_o`=0.
- Signed: −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- Divide by zero: 5 / 0 → `ready_o` and `div_zero_o` high after 1 cycle; `result_o`=0.
  - Drop `start_i` → all three outputs are 0 one edge later.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
  - Unsigned, same operands → quotient 0, remainder 0x80000000.
- Annul in ON: assert `annul_i` on cycle 10 → next edge `busy_o`=0, state FREE, no `ready_o` pulse.
  - Then a fresh start with 9 / 3 → quotient 3, remainder 0.
- Reset and parametrisation:
  - Assert `rst` mid-division at cycle 5 → all outputs 0 on the next edge; the held `start_i` then restarts cleanly.
  - `WIDTH`=8: unsigned 200 / 13 → {8'd5, 8'd15} after 9 cycles.

Source files
------------

// File: rtl/div_param.sv
// div_param: parametrised multi-cycle radix-2 restoring divider.
// Operands and sign mode are latched when a request is accepted, one quotient
// bit is produced per cycle, and the signed result is held until the EX stage
// releases start_i. A zero divisor short-circuits to a flagged zero result.
module div_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div_zero_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t                 state_q, state_n;
  logic [2*WIDTH:0]       dividend_q, dividend_n;
  logic [WIDTH-1:0]       divisor_q, divisor_n;
  logic [CW-1:0]          cnt_q, cnt_n;
  logic                   qneg_q, qneg_n;
  logic                   rneg_q, rneg_n;
  logic [2*WIDTH-1:0]     result_n;
  logic                   ready_n;
  logic                   busy_n;
  logic                   div_zero_n;

  // Datapath helpers
  logic                   neg1, neg2;
  logic [WIDTH-1:0]       mag1, mag2;
  logic [2*WIDTH:0]       shifted;
  logic [WIDTH+1:0]       diff;
  logic [WIDTH-1:0]       q_mag, r_mag;
  logic [WIDTH-1:0]       q_res, r_res;

  // Next-state, datapath and registered-output values for the divider FSM
  always_comb begin
    state_n    = state_q;
    dividend_n = dividend_q;
    divisor_n  = divisor_q;
    cnt_n      = cnt_q;
    qneg_n     = qneg_q;
    rneg_n     = rneg_q;
    result_n   = result_o;
    ready_n    = ready_o;
    div_zero_n = div_zero_o;

    neg1 = signed_div_i & opdata1_i[WIDTH-1];
    neg2 = signed_div_i & opdata2_i[WIDTH-1];
    mag1 = neg1 ? ('0 - opdata1_i) : opdata1_i;
    mag2 = neg2 ? ('0 - opdata2_i) : opdata2_i;

    // Upper WIDTH+1 bits of the shifted register minus the divisor; the
    // extra top bit of diff is the borrow (negative result).
    shifted = {dividend_q[2*WIDTH-1:0], 1'b0};
    diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor_q};

    // The remainder is always smaller than the divisor, so the top bit of the
    // upper field is zero by the time the result is taken.
    q_mag = dividend_q[WIDTH-1:0];
    r_mag = WIDTH'(dividend_q[2*WIDTH:WIDTH]);
    q_res = qneg_q ? ('0 - q_mag) : q_mag;
    r_res = rneg_q ? ('0 - r_mag) : r_mag;

    case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            divisor_n = '0;
            state_n   = BY_ZERO;
          end else begin
            divisor_n  = mag2;
            qneg_n     = neg1 ^ neg2;
            rneg_n     = neg1;
            dividend_n = {{(WIDTH+1){1'b0}}, mag1};
            cnt_n      = '0;
            state_n    = ON;
          end
        end
      end

      BY_ZERO: begin
        result_n   = '0;
        ready_n    = 1'b1;
        div_zero_n = 1'b1;
        state_n    = END;
      end

      ON: begin
        if (annul_i) begin
          cnt_n   = '0;
          state_n = FREE;
        end else if (cnt_q != CNT_LAST) begin
          if (!diff[WIDTH+1]) begin
            dividend_n = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
          end else begin
            dividend_n = shifted;
          end
          cnt_n = cnt_q + CW'(1);
        end else begin
          result_n   = {r_res, q_res};
          ready_n    = 1'b1;
          div_zero_n = 1'b0;
          state_n    = END;
        end
      end

      END: begin
        if (annul_i || !start_i) begin
          result_n   = '0;
          ready_n    = 1'b0;
          div_zero_n = 1'b0;
          state_n    = FREE;
        end
      end

      default: begin
        state_n = FREE;
      end
    endcase

    busy_n = (state_n == BY_ZERO) || (state_n == ON);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FREE;
      dividend_q <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
      busy_o     <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      state_q    <= state_n;
      dividend_q <= dividend_n;
      divisor_q  <= divisor_n;
      cnt_q      <= cnt_n;
      qneg_q     <= qneg_n;
      rneg_q     <= rneg_n;
      result_o   <= result_n;
      ready_o    <= ready_n;
      busy_o     <= busy_n;
      div_zero_o <= div_zero_n;
    end
  end

endmodule
